// File: rtl/rtc_field_sequencer_pkg.sv
// Shared definitions for the RTC display field sequencer: FSM states, default
// field layout and timer presets, plus a BCD digit helper.
package rtc_field_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EMIT = 2'd2
  } state_e;

  localparam int F_D  = 0;
  localparam int F_ME = 1;
  localparam int F_A  = 2;
  localparam int F_H  = 3;
  localparam int F_M  = 4;
  localparam int F_S  = 5;
  localparam int F_HT = 6;
  localparam int F_MT = 7;
  localparam int F_ST = 8;

  localparam logic [7:0] TMAX_HOURS  = 8'h23;
  localparam logic [7:0] TMAX_MINSEC = 8'h59;

  function automatic logic bcd_digit_ok(input logic [3:0] d);
    return d <= 4'd9;
  endfunction

endpackage

// File: rtl/rtc_field_sequencer_bcd_sub8.sv
// Combinational two-digit BCD subtract a - b with borrow from ones to tens.
module bcd_sub8
  import rtc_field_sequencer_pkg::*;
(
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] result_o,
  output logic       underflow_o,
  output logic       invalid_o
);

  logic [4:0] ones_raw;
  logic [4:0] tens_raw;
  logic [3:0] ones_fix;
  logic       borrow;

  always_comb begin
    ones_raw    = {1'b0, a_i[3:0]} - {1'b0, b_i[3:0]};
    borrow      = ones_raw[4];
    // Adding 10 modulo 16 turns the two's-complement ones digit back into BCD.
    ones_fix    = ones_raw[3:0] + (borrow ? 4'd10 : 4'd0);
    tens_raw    = {1'b0, a_i[7:4]} - {1'b0, b_i[7:4]} - {4'b0000, borrow};
    result_o    = {tens_raw[3:0], ones_fix};
    underflow_o = tens_raw[4];
    invalid_o   = !bcd_digit_ok(a_i[3:0]) || !bcd_digit_ok(a_i[7:4]) ||
                  !bcd_digit_ok(b_i[3:0]) || !bcd_digit_ok(b_i[7:4]);
  end

endmodule

// File: rtl/rtc_field_sequencer.sv
// Snapshots all RTC BCD fields on frame_start and streams one processed byte
// per accepted transfer (12h hour masking, saturating BCD countdown).
module rtc_field_sequencer
  import rtc_field_sequencer_pkg::*;
#(
  parameter int N_FIELDS = 9,
  parameter int N_TIMER  = 3,
  parameter int HOUR_IDX = F_H,
  parameter int IDX_W    = 4
) (
  input  logic                                       clk,
  input  logic                                       reset_n,
  input  logic                                       frame_start,
  input  logic [8*N_FIELDS-1:0]                      fields_in,
  input  logic [8*((N_TIMER > 0) ? N_TIMER : 1)-1:0] timer_max,
  input  logic                                       mode_12h,
  output logic [7:0]                                 out_data,
  output logic [IDX_W-1:0]                           out_idx,
  output logic                                       out_pm,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic                                       busy,
  output logic                                       overrun
);

  localparam int               NT1      = (N_TIMER > 0) ? N_TIMER : 1;
  localparam int               T_BASE   = N_FIELDS - N_TIMER;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FIELDS - 1);
  localparam logic [IDX_W-1:0] HOUR_I   = IDX_W'(HOUR_IDX);

  state_e                     state_q, state_d;
  logic [N_FIELDS-1:0][7:0]   snap_f_q, snap_f_d;
  logic [NT1-1:0][7:0]        snap_tm_q, snap_tm_d;
  logic                       snap_12h_q, snap_12h_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [7:0]                 data_q, data_d;
  logic [IDX_W-1:0]           oidx_q, oidx_d;
  logic                       pm_q, pm_d;
  logic                       valid_q, valid_d;
  logic                       busy_q, busy_d;
  logic                       ovr_q, ovr_d;

  logic [7:0] cur_val, cur_max, sub_res, proc_val;
  logic       is_timer, sub_uf, sub_inv;

  always_comb begin : field_sel
    cur_val  = 8'h00;
    cur_max  = 8'h00;
    is_timer = 1'b0;
    for (int i = 0; i < N_FIELDS; i++)
      if (idx_q == IDX_W'(i)) cur_val = snap_f_q[i];
    for (int j = 0; j < N_TIMER; j++)
      if (idx_q == IDX_W'(T_BASE + j)) begin
        cur_max  = snap_tm_q[j];
        is_timer = 1'b1;
      end
  end

  bcd_sub8 u_sub (
    .a_i        (cur_max),
    .b_i        (cur_val),
    .result_o   (sub_res),
    .underflow_o(sub_uf),
    .invalid_o  (sub_inv)
  );

  always_comb begin : field_proc
    proc_val = cur_val;
    // Countdown saturates at zero rather than wrapping on bad or late input.
    if (is_timer)
      proc_val = (sub_uf || sub_inv) ? 8'h00 : sub_res;
    else if (snap_12h_q && idx_q == HOUR_I)
      proc_val = cur_val & 8'h7F;
  end

  always_comb begin : fsm_next
    state_d    = state_q;
    snap_f_d   = snap_f_q;
    snap_tm_d  = snap_tm_q;
    snap_12h_d = snap_12h_q;
    idx_d      = idx_q;
    data_d     = data_q;
    oidx_d     = oidx_q;
    pm_d       = pm_q;
    valid_d    = valid_q;
    busy_d     = busy_q;
    ovr_d      = frame_start && (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: if (frame_start) begin
        snap_f_d   = fields_in;
        snap_tm_d  = timer_max;
        snap_12h_d = mode_12h;
        idx_d      = '0;
        busy_d     = 1'b1;
        state_d    = ST_LOAD;
      end
      ST_LOAD: begin
        data_d  = proc_val;
        oidx_d  = idx_q;
        pm_d    = snap_12h_q && snap_f_q[HOUR_IDX][7];
        valid_d = 1'b1;
        state_d = ST_EMIT;
      end
      ST_EMIT: if (out_ready) begin
        valid_d = 1'b0;
        if (idx_q == LAST_IDX) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      snap_f_q   <= '0;
      snap_tm_q  <= '0;
      snap_12h_q <= 1'b0;
      idx_q      <= '0;
      data_q     <= 8'h00;
      oidx_q     <= '0;
      pm_q       <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      snap_f_q   <= snap_f_d;
      snap_tm_q  <= snap_tm_d;
      snap_12h_q <= snap_12h_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      oidx_q     <= oidx_d;
      pm_q       <= pm_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      ovr_q      <= ovr_d;
    end
  end

  assign out_data  = data_q;
  assign out_idx   = oidx_q;
  assign out_pm    = pm_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_rtc_field_sequencer.sv
// Directed bench for rtc_field_sequencer: table of frames with hand-computed
// bytes, plus backpressure, overrun and mid-frame reset sequences.
module tb_rtc_field_sequencer;

  logic        clk;
  logic        reset_n;
  logic        frame_start;
  logic [71:0] fields_in;
  logic [23:0] timer_max;
  logic        mode_12h;
  logic [7:0]  out_data;
  logic [3:0]  out_idx;
  logic        out_pm;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        overrun;

  rtc_field_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .frame_start(frame_start),
    .fields_in  (fields_in),
    .timer_max  (timer_max),
    .mode_12h   (mode_12h),
    .out_data   (out_data),
    .out_idx    (out_idx),
    .out_pm     (out_pm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [71:0] f;
    logic [23:0] tm;
    logic        m;
    logic [71:0] exp;
    logic        pm;
  } vec_t;

  localparam int NV = 7;
  vec_t vt [NV];

  int pass_cnt = 0;
  int tot_cnt  = 0;

  logic [7:0] cap_data [9];
  logic [3:0] cap_idx  [9];
  logic       cap_pm   [9];
  int         cap_n, fv_cyc, end_cyc, ov_n;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
  endtask

  // Starts a frame at the next posedge and follows it until busy drops.
  task automatic run_frame(input int vi, input bit rnd, input int extra_fs, input bit scramble);
    int         cyc;
    bit         prev_stall;
    logic [7:0] pd;
    logic [3:0] pi;
    logic       pp;
    cap_n = 0; fv_cyc = -1; ov_n = 0; prev_stall = 0;
    pd = 8'h00; pi = 4'h0; pp = 1'b0;
    for (int i = 0; i < 9; i++) begin
      cap_data[i] = 8'hxx; cap_idx[i] = 4'hx; cap_pm[i] = 1'bx;
    end
    fields_in   = vt[vi].f;
    timer_max   = vt[vi].tm;
    mode_12h    = vt[vi].m;
    frame_start = 1'b1;
    out_ready   = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    cyc = 0;
    while (cyc < 300) begin
      if (overrun) ov_n++;
      if (!busy) break;
      if (out_valid && fv_cyc < 0) fv_cyc = cyc;
      if (prev_stall) begin
        check($sformatf("v%0d stall valid c%0d", vi, cyc), out_valid, 1'b1);
        check($sformatf("v%0d stall data c%0d", vi, cyc), out_data, pd);
        check($sformatf("v%0d stall idx c%0d", vi, cyc), out_idx, pi);
        check($sformatf("v%0d stall pm c%0d", vi, cyc), out_pm, pp);
      end
      out_ready   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      frame_start = (cyc == extra_fs);
      if (scramble && cyc == 5) begin
        fields_in = ~vt[vi].f;
        timer_max = ~vt[vi].tm;
        mode_12h  = ~vt[vi].m;
      end
      if (out_valid && out_ready) begin
        if (cap_n < 9) begin
          cap_data[cap_n] = out_data;
          cap_idx[cap_n]  = out_idx;
          cap_pm[cap_n]   = out_pm;
        end
        cap_n++;
      end
      prev_stall = out_valid && !out_ready;
      pd = out_data; pi = out_idx; pp = out_pm;
      @(negedge clk);
      cyc++;
    end
    frame_start = 1'b0;
    out_ready   = 1'b1;
    end_cyc     = cyc;
    if (cyc >= 300) check($sformatf("v%0d frame timeout busy", vi), busy, 1'b0);
  endtask

  task automatic check_bytes(input int vi, input string tag);
    logic [71:0] e;
    e = vt[vi].exp;
    check($sformatf("%s v%0d byte count", tag, vi), cap_n, 9);
    for (int i = 0; i < 9; i++) begin
      check($sformatf("%s v%0d idx%0d data", tag, vi, i), cap_data[i], e[i*8 +: 8]);
      check($sformatf("%s v%0d idx%0d out_idx", tag, vi, i), cap_idx[i], i);
      check($sformatf("%s v%0d idx%0d pm", tag, vi, i), cap_pm[i], vt[vi].pm);
    end
  endtask

  initial begin
    vt[0] = '{f: 72'h59_15_09_45_30_09_16_06_15, tm: 24'h59_59_23, m: 1'b0,
              exp: 72'h00_44_14_45_30_09_16_06_15, pm: 1'b0};
    vt[1] = '{f: 72'h59_15_09_45_30_91_16_06_15, tm: 24'h59_59_23, m: 1'b1,
              exp: 72'h00_44_14_45_30_11_16_06_15, pm: 1'b1};
    vt[2] = '{f: 72'h59_15_09_45_30_91_16_06_15, tm: 24'h59_59_23, m: 1'b0,
              exp: 72'h00_44_14_45_30_91_16_06_15, pm: 1'b0};
    vt[3] = '{f: 72'h00_00_24_45_30_09_16_06_15, tm: 24'h59_59_23, m: 1'b1,
              exp: 72'h59_59_00_45_30_09_16_06_15, pm: 1'b0};
    vt[4] = '{f: 72'h00_60_1A_45_30_09_16_06_15, tm: 24'h59_59_23, m: 1'b0,
              exp: 72'h59_00_00_45_30_09_16_06_15, pm: 1'b0};
    vt[5] = '{f: 72'h01_00_23_45_30_09_16_06_15, tm: 24'h59_59_23, m: 1'b0,
              exp: 72'h58_59_00_45_30_09_16_06_15, pm: 1'b0};
    vt[6] = '{f: 72'h29_00_05_45_30_92_16_06_15, tm: 24'h30_9F_10, m: 1'b1,
              exp: 72'h01_00_05_45_30_12_16_06_15, pm: 1'b1};

    reset_n = 1'b0; frame_start = 1'b0; fields_in = '0; timer_max = '0;
    mode_12h = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset out_valid", out_valid, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset overrun", overrun, 1'b0);
    check("reset out_data", out_data, 8'h00);
    check("reset out_idx", out_idx, 4'h0);
    check("reset out_pm", out_pm, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < NV; v++) begin
      run_frame(v, 1'b0, -1, 1'b0);
      check_bytes(v, "table");
      check($sformatf("table v%0d first valid cycle", v), fv_cyc, 1);
      check($sformatf("table v%0d busy drop cycle", v), end_cyc, 18);
      check($sformatf("table v%0d no overrun", v), ov_n, 0);
      @(negedge clk);
    end

    // Random backpressure with inputs changing mid-frame.
    run_frame(1, 1'b1, -1, 1'b1);
    check_bytes(1, "bp");
    @(negedge clk);
    run_frame(6, 1'b1, -1, 1'b1);
    check_bytes(6, "bp");
    @(negedge clk);

    // Second frame_start while busy.
    run_frame(0, 1'b0, 4, 1'b0);
    check_bytes(0, "ovr_mid");
    check("ovr_mid pulse count", ov_n, 1);
    check("ovr_mid busy drop cycle", end_cyc, 18);
    @(negedge clk);

    // frame_start on the final accept edge must not restart.
    run_frame(5, 1'b0, 17, 1'b0);
    check_bytes(5, "ovr_last");
    check("ovr_last pulse count", ov_n, 1);
    repeat (3) @(negedge clk);
    check("ovr_last no restart busy", busy, 1'b0);
    check("ovr_last no restart valid", out_valid, 1'b0);

    // Async reset in the middle of a stalled EMIT.
    fields_in = vt[0].f; timer_max = vt[0].tm; mode_12h = vt[0].m;
    frame_start = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    frame_start = 1'b0;
    @(negedge clk);
    check("pre-reset valid", out_valid, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("mid reset out_valid", out_valid, 1'b0);
    check("mid reset busy", busy, 1'b0);
    check("mid reset overrun", overrun, 1'b0);
    check("mid reset out_data", out_data, 8'h00);
    @(negedge clk);
    reset_n = 1'b1; out_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("post reset idle valid", out_valid, 1'b0);
    check("post reset idle busy", busy, 1'b0);
    run_frame(2, 1'b0, -1, 1'b0);
    check_bytes(2, "post_reset");
    check("post_reset first valid cycle", fv_cyc, 1);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
